// File: rtl/trng_tune_ctrl.sv
// Calibration and harvesting controller for the metastable RS-latch entropy source.
// Steps the S/R delay lines until the windowed pulse-count average is in band, then packs LSBs into bytes.
module trng_tune_ctrl #(
    parameter int WINDOW    = 16,
    parameter int LO_TH     = 4,
    parameter int HI_TH     = 12,
    parameter int SETTLE    = 4,
    parameter int MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       sample_valid,
    input  logic [3:0] sample_cnt,
    output logic [2:0] sdelay,
    output logic [2:0] rdelay,
    output logic       locked,
    output logic       fail,
    output logic       overrun,
    output logic [7:0] rnd_data,
    output logic       rnd_valid,
    input  logic       rnd_ready
);

    localparam int LW = $clog2(WINDOW);
    localparam int SW = 4 + LW;
    localparam int CW = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    state_t          state_r, state_nx;
    logic [CW-1:0]   cnt_r, cnt_nx;
    logic [SW-1:0]   sum_r, sum_nx, sum_acc_s;
    logic [7:0]      try_r, try_nx, try_inc_s;
    logic [2:0]      sdelay_r, sd_nx, rdelay_r, rd_nx;
    logic [7:0]      pk_r, pk_nx, byte_s;
    logic [2:0]      pk_cnt_r, pkc_nx;
    logic [7:0]      data_r, data_nx;
    logic            valid_r, valid_nx;
    logic            overrun_r, ovr_nx;
    logic            locked_r, fail_r;
    logic [3:0]      avg_s;
    logic            win_end_s, too_lo_s, too_hi_s, oob_s, accept_s;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state, window decision, packer and output buffer logic
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        sum_nx    = sum_r;
        try_nx    = try_r;
        sd_nx     = sdelay_r;
        rd_nx     = rdelay_r;
        pk_nx     = pk_r;
        pkc_nx    = pk_cnt_r;
        data_nx   = data_r;
        ovr_nx    = overrun_r;
        sum_acc_s = sum_r + SW'(sample_cnt);
        avg_s     = sum_acc_s[SW-1:LW];
        win_end_s = sample_valid && (cnt_r == CW'(WINDOW - 1));
        too_lo_s  = (avg_s < 4'(LO_TH));
        too_hi_s  = (avg_s > 4'(HI_TH));
        oob_s     = too_lo_s || too_hi_s;
        try_inc_s = try_r + 8'd1;
        byte_s    = {sample_cnt[0], pk_r[7:1]};
        accept_s  = valid_r && rnd_ready;
        if (accept_s) begin
            valid_nx = 1'b0;
        end else begin
            valid_nx = valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nx = ST_SETTLE;
                    cnt_nx   = '0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (sample_valid && (cnt_r == CW'(SETTLE - 1))) begin
                    state_nx = ST_MEASURE;
                    cnt_nx   = '0;
                    sum_nx   = '0;
                end else if (sample_valid) begin
                    cnt_nx = cnt_r + 7'd1;
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (win_end_s) begin
                    cnt_nx = '0;
                    sum_nx = '0;
                    if (oob_s) begin
                        // Saturated shifts still consume a try
                        if (too_lo_s) begin
                            sd_nx = {sdelay_r[1:0], 1'b1};
                            rd_nx = 3'b000;
                        end else begin
                            sd_nx = {1'b0, sdelay_r[2:1]};
                            rd_nx = {rdelay_r[1:0], 1'b1};
                        end
                        try_nx   = try_inc_s;
                        state_nx = (try_inc_s == 8'(MAX_TRIES)) ? ST_FAIL : ST_SETTLE;
                        pk_nx    = 8'd0;
                        pkc_nx   = 3'd0;
                    end else begin
                        state_nx = ST_LOCKED;
                        try_nx   = 8'd0;
                    end
                end else if (sample_valid) begin
                    cnt_nx = cnt_r + 7'd1;
                    sum_nx = sum_acc_s;
                end else begin
                    cnt_nx = cnt_r;
                end

                // The bit on an out-of-band window-end strobe belongs to a stale calibration
                if ((state_r == ST_LOCKED) && sample_valid && !(win_end_s && oob_s)) begin
                    pk_nx  = byte_s;
                    pkc_nx = pk_cnt_r + 3'd1;
                    if ((pk_cnt_r == 3'd7) && (!valid_r || accept_s)) begin
                        data_nx  = byte_s;
                        valid_nx = 1'b1;
                    end else if (pk_cnt_r == 3'd7) begin
                        ovr_nx = 1'b1;
                    end else begin
                        ovr_nx = overrun_r;
                    end
                end else begin
                    pkc_nx = pkc_nx;
                end
            end
            ST_FAIL: begin
                state_nx = ST_FAIL;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (!enable) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            sum_nx   = '0;
            try_nx   = 8'd0;
            sd_nx    = 3'd0;
            rd_nx    = 3'd0;
            pk_nx    = 8'd0;
            pkc_nx   = 3'd0;
            data_nx  = 8'd0;
            valid_nx = 1'b0;
            ovr_nx   = 1'b0;
        end else begin
            state_nx = state_nx;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r     <= '0;
            sum_r     <= '0;
            try_r     <= 8'd0;
            sdelay_r  <= 3'd0;
            rdelay_r  <= 3'd0;
            pk_r      <= 8'd0;
            pk_cnt_r  <= 3'd0;
            data_r    <= 8'd0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            locked_r  <= 1'b0;
            fail_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nx;
            sum_r     <= sum_nx;
            try_r     <= try_nx;
            sdelay_r  <= sd_nx;
            rdelay_r  <= rd_nx;
            pk_r      <= pk_nx;
            pk_cnt_r  <= pkc_nx;
            data_r    <= data_nx;
            valid_r   <= valid_nx;
            overrun_r <= ovr_nx;
            locked_r  <= (state_nx == ST_LOCKED);
            fail_r    <= (state_nx == ST_FAIL);
        end
    end

    assign sdelay    = sdelay_r;
    assign rdelay    = rdelay_r;
    assign locked    = locked_r;
    assign fail      = fail_r;
    assign overrun   = overrun_r;
    assign rnd_data  = data_r;
    assign rnd_valid = valid_r;

endmodule

// File: tb/tb_trng_tune_ctrl.sv
// Self-checking bench for trng_tune_ctrl: directed test-plan steps plus randomized
// traffic, all compared against a window-queue/level-based reference model.
module tb_trng_tune_ctrl;

    localparam int WINDOW    = 16;
    localparam int LO_TH     = 4;
    localparam int HI_TH     = 12;
    localparam int SETTLE    = 4;
    localparam int MAX_TRIES = 4;

    localparam int M_IDLE    = 0;
    localparam int M_SETTLE  = 1;
    localparam int M_MEASURE = 2;
    localparam int M_LOCKED  = 3;
    localparam int M_FAIL    = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic       sample_valid;
    logic [3:0] sample_cnt;
    logic       rnd_ready;
    logic [2:0] sdelay;
    logic [2:0] rdelay;
    logic       locked;
    logic       fail;
    logic       overrun;
    logic [7:0] rnd_data;
    logic       rnd_valid;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int   m_mode;
    int   m_settle;
    int   m_s;
    int   m_r;
    int   m_tries;
    int   m_win[$];
    bit   m_bits[$];
    bit   m_valid;
    bit   m_ovr;
    logic [7:0] m_data;

    trng_tune_ctrl #(
        .WINDOW(WINDOW), .LO_TH(LO_TH), .HI_TH(HI_TH),
        .SETTLE(SETTLE), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .sample_valid(sample_valid), .sample_cnt(sample_cnt),
        .sdelay(sdelay), .rdelay(rdelay), .locked(locked), .fail(fail),
        .overrun(overrun), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] thermo(input int lvl);
        logic [2:0] ones;
        ones = 3'b111;
        return ones >> (3 - lvl);
    endfunction

    function automatic logic [17:0] dut_vec();
        return {sdelay, rdelay, locked, fail, overrun, rnd_valid, rnd_data};
    endfunction

    function automatic logic [17:0] model_vec();
        return {thermo(m_s), thermo(m_r), m_mode == M_LOCKED, m_mode == M_FAIL,
                m_ovr, m_valid, m_data};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_settle = 0; m_s = 0; m_r = 0; m_tries = 0;
        m_win.delete(); m_bits.delete();
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
    endtask

    // One rising edge of the reference model, using the inputs the bench is driving
    task automatic model_edge();
        bit acc, load, was_locked, oob;
        int sum, avg;
        logic [7:0] b;
        acc = m_valid && rnd_ready;
        load = 1'b0; oob = 1'b0;
        was_locked = (m_mode == M_LOCKED);
        if (!enable) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: begin m_mode = M_SETTLE; m_settle = SETTLE; end
            M_SETTLE: if (sample_valid) begin
                m_settle--;
                if (m_settle == 0) begin m_mode = M_MEASURE; m_win.delete(); end
            end
            M_MEASURE, M_LOCKED: if (sample_valid) begin
                m_win.push_back(int'(sample_cnt));
                if (m_win.size() == WINDOW) begin
                    sum = 0;
                    foreach (m_win[i]) sum += m_win[i];
                    avg = sum / WINDOW;
                    m_win.delete();
                    if (avg < LO_TH) begin
                        m_s = (m_s < 3) ? m_s + 1 : 3; m_r = 0; oob = 1'b1;
                    end else if (avg > HI_TH) begin
                        m_s = (m_s > 0) ? m_s - 1 : 0; m_r = (m_r < 3) ? m_r + 1 : 3; oob = 1'b1;
                    end else begin
                        m_mode = M_LOCKED; m_tries = 0;
                    end
                    if (oob) begin
                        m_tries++;
                        m_mode = (m_tries == MAX_TRIES) ? M_FAIL : M_SETTLE;
                        m_settle = SETTLE;
                        m_bits.delete();
                    end
                end
                if (was_locked && !oob) begin
                    m_bits.push_back(sample_cnt[0]);
                    if (m_bits.size() == 8) begin
                        b = 8'h00;
                        foreach (m_bits[i]) b[i] = m_bits[i];
                        m_bits.delete();
                        if (!m_valid || acc) begin m_data = b; load = 1'b1; end
                        else m_ovr = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (load) m_valid = 1'b1;
        else if (acc) m_valid = 1'b0;
    endtask

    // Called at a falling edge: drive, clock, then compare at the next falling edge
    task automatic cyc(input bit en, input bit sv, input logic [3:0] c, input bit rdy);
        enable = en; sample_valid = sv; sample_cnt = c; rnd_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic strobes(input int n, input logic [3:0] c, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, c, rdy);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] byte_a;
        logic [7:0] byte_b;
        bit bt;
        int kind;
        logic [3:0] c;

        resetn = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_cnt = 4'd0; rnd_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        resetn = 1'b1;

        // calibration upward, then lock
        cyc(1'b1, 1'b1, 4'd2, 1'b1);
        strobes(20, 4'd2, 1'b1);
        check("cal_s001", 32'(sdelay), 32'h1);
        strobes(20, 4'd2, 1'b1);
        check("cal_s011", 32'(sdelay), 32'h3);
        strobes(19, 4'd2, 1'b1);
        check("cal_s011_hold", 32'(sdelay), 32'h3);
        strobes(1, 4'd2, 1'b1);
        check("cal_s111", 32'(sdelay), 32'h7);
        strobes(20, 4'd8, 1'b1);
        check("cal_locked", 32'({locked, sdelay}), 32'hF);

        // byte packing, LSB first
        pat = 8'h4D;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, {3'b100, pat[i]}, 1'b1);
        check("byte_valid", 32'({rnd_valid, rnd_data}), 32'h14D);
        cyc(1'b1, 1'b0, 4'd8, 1'b1);
        check("byte_taken", 32'(rnd_valid), 32'h0);

        // backpressure: first byte held, second dropped
        byte_a = 8'h00;
        for (int i = 0; i < 16; i++) begin
            bt = 1'($urandom_range(0, 1));
            if (i < 8) byte_a[i] = bt;
            cyc(1'b1, 1'b1, {3'b100, bt}, 1'b0);
        end
        check("bp_hold", 32'({overrun, rnd_valid, rnd_data}), 32'({2'b11, byte_a}));
        byte_b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bt = 1'($urandom_range(0, 1));
            byte_b[i] = bt;
            cyc(1'b1, 1'b1, {3'b100, bt}, (i == 7));
        end
        check("bp_reload", 32'({rnd_valid, rnd_data}), 32'({1'b1, byte_b}));
        cyc(1'b1, 1'b0, 4'd8, 1'b1);

        // opposite steer
        cyc(1'b0, 1'b0, 4'd0, 1'b0);
        check("disable_clear", 32'(dut_vec()), 32'd0);
        cyc(1'b1, 1'b1, 4'd14, 1'b1);
        strobes(20, 4'd14, 1'b1);
        check("steer_r001", 32'({sdelay, rdelay}), 32'h01);
        strobes(20, 4'd14, 1'b1);
        check("steer_r011", 32'({sdelay, rdelay}), 32'h03);

        // failure after MAX_TRIES adjustments
        cyc(1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 4'd0, 1'b1);
        strobes(79, 4'd0, 1'b1);
        check("fail_not_yet", 32'(fail), 32'h0);
        strobes(1, 4'd0, 1'b1);
        check("fail_set", 32'({fail, sdelay}), 32'hF);
        strobes(5, 4'd0, 1'b1);
        check("fail_held", 32'({fail, locked}), 32'h2);
        cyc(1'b0, 1'b1, 4'd0, 1'b1);
        check("fail_cleared", 32'(dut_vec()), 32'd0);

        // randomized traffic in segments with different count distributions
        for (int seg = 0; seg < 20; seg++) begin
            kind = $urandom_range(0, 3);
            for (int i = 0; i < 200; i++) begin
                case (kind)
                    0: c = 4'($urandom_range(0, 5));
                    1: c = 4'($urandom_range(10, 15));
                    2: c = 4'($urandom_range(5, 11));
                    default: c = 4'($urandom_range(0, 15));
                endcase
                cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 7), c,
                    1'($urandom_range(0, 1)));
            end
        end

        // asynchronous reset while holding a byte mid-packing
        cyc(1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 4'd8, 1'b0);
        strobes(20, 4'd8, 1'b0);
        strobes(11, 4'd9, 1'b0);
        check("pre_reset_state", 32'({locked, rnd_valid}), 32'h3);
        #2 resetn = 1'b0;
        #1 check("async_reset", 32'(dut_vec()), 32'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        cyc(1'b1, 1'b1, 4'd8, 1'b1);
        strobes(20, 4'd8, 1'b1);
        check("relock", 32'(locked), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trng_tune_ctrl.md
# trng_tune_ctrl

Calibration and harvesting controller for the metastable RS-latch entropy source. It consumes the per-window pulse count produced by the sampling logic and steps the S/R delay-line selects until the average count sits in the metastable band. It then keeps monitoring for drift and packs the LSB of each locked-window count into bytes, delivered over a valid/ready interface.

## Interface
- `WINDOW`, 16: samples per measurement window; power of two, 2..64.
- `LO_TH`, 4: average below this steers sdelay up.
- `HI_TH`, 12: average above this steers rdelay up.
- `SETTLE`, 4: samples discarded after every delay change; 1..15.
- `MAX_TRIES`, 16: adjustments allowed without lock before FAIL; 1..255.
- `clk` in 1: single clock for all logic.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: level; low forces IDLE.
- `sample_valid` in 1: one-cycle strobe, one per sampling window.
- `sample_cnt` in 4: pulse count for that window; qualified by `sample_valid`.
- `sdelay` out 3: S delay-line select, thermometer code.
- `rdelay` out 3: R delay-line select, thermometer code.
- `locked` out 1: high in LOCKED.
- `fail` out 1: high in FAIL.
- `overrun` out 1: sticky; a byte was dropped.
- `rnd_data` out 8: harvested byte.
- `rnd_valid` out 1: `rnd_data` is valid.
- `rnd_ready` in 1: consumer accepts the byte.

## Operation
- States: IDLE, SETTLE, MEASURE, LOCKED, FAIL.
- Reset and IDLE: all outputs 0; sum, sample counter, try counter, packer and buffer cleared.
- IDLE -> SETTLE when `enable` is high.
- SETTLE: count `SETTLE` strobes, then go to MEASURE with sum cleared.
- MEASURE and LOCKED: accumulate `sample_cnt` into sum over `WINDOW` strobes.
  - Sum width is 4+log2(WINDOW) and never wraps.
  - avg = sum >> log2(WINDOW), 4 bits.
- Window end in MEASURE:
  - If avg < LO_TH: sdelay <= {sdelay[1:0],1}; rdelay <= 0; try+1; go to SETTLE.
  - Else if avg > HI_TH: sdelay <= {0,sdelay[2:1]}; rdelay <= {rdelay[1:0],1}; try+1; go to SETTLE.
  - Else: go to LOCKED; try counter cleared.
  - Saturation: a shift that leaves the code unchanged (111 up, 000 down) still counts as a try.
  - If try reaches `MAX_TRIES` on an adjusting decision, go to FAIL instead of SETTLE. The delays keep their new values.
- LOCKED:
  - Each strobe shifts sample_cnt[0] into the packer, LSB first.
  - On the 8th bit:
    - If the buffer is empty, or `rnd_valid && rnd_ready` this cycle: load `rnd_data`, set `rnd_valid`.
    - Otherwise drop the byte and set `overrun`.
  - A window decision out of band applies the same delay update as in MEASURE, goes to SETTLE and discards partial packer bits. The buffered byte is kept.
  - A bit arriving on the same strobe that ends an out-of-band window is discarded.
- FAIL: hold the delays; `fail`=1. Leave only through `enable` low.
- `enable` low in any state: next edge enters IDLE.
  - Cleared: delays, packer, buffer (`rnd_valid`=0), `overrun`, `fail`, `locked`, try counter.
  - Any in-flight byte is lost.

## Timing
- All outputs are registered.
- `sdelay`, `rdelay` and state update on the edge following the `sample_valid` that ends the window.
  - `locked` rises 1 cycle after that strobe.
- Byte latency: `rnd_valid` rises 1 cycle after the 8th locked strobe.
- Handshake:
  - Transfer when `rnd_valid && rnd_ready` at a rising edge.
  - `rnd_valid` drops the next cycle unless a new byte loads on that same edge.
  - `rnd_data` is stable while `rnd_valid` is high and not yet accepted.
- Strobes spaced 1 cycle apart are handled; no strobe is lost in any state transition.
- `resetn` assertion clears state immediately, independent of `clk`. Deassertion is synchronized externally.

## Test plan
- Calibration to lock: `enable`=1, constant `sample_cnt`=2 -> sdelay steps 001, 011, 111 after SETTLE+WINDOW = 20 strobes each.
  - Switch to cnt=8 -> `locked`=1 after the next full window; sdelay unchanged.
- Opposite steer: cnt=14 from IDLE -> rdelay=001 and sdelay=000 after 20 strobes; rdelay=011 after 40.
- Byte packing: locked, LSB sequence 1,0,1,1,0,0,1,0 with `rnd_ready`=1 -> `rnd_data`=0x4D, `rnd_valid` high for 1 cycle.
- Backpressure: `rnd_ready`=0 over 16 locked strobes -> first byte held, `overrun`=1.
  - Ready and a new byte in the same cycle -> transfer plus reload, no overrun.
- Failure: cnt=0 forever with `MAX_TRIES`=4 -> `fail`=1 after 80 strobes, sdelay=111.
  - `enable` low -> all outputs 0 next cycle.
- Async reset mid-byte: drop `resetn` between edges while LOCKED with `rnd_valid`=1 -> all outputs 0 before the next edge.
